// File: rtl/nes_button_events.sv
// nes_button_events
// Turns the eight NES button levels into press / release / auto-repeat
// events and queues them in a small show-ahead FIFO with valid/ready.
module nes_button_events #(
   parameter int STARTUP_CYCLES = 8192,
   parameter int REPEAT_DELAY   = 25_000_000,
   parameter int REPEAT_PERIOD  = 5_000_000,
   parameter int FIFO_DEPTH     = 4,
   parameter int CNT_W          = 25
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          A,
   input  logic                          B,
   input  logic                          select,
   input  logic                          start,
   input  logic                          up,
   input  logic                          down,
   input  logic                          left,
   input  logic                          right,
   output logic                          ev_valid,
   input  logic                          ev_ready,
   output logic [2:0]                    ev_code,
   output logic [1:0]                    ev_type,
   output logic [7:0]                    btn_level,
   output logic [$clog2(FIFO_DEPTH):0]   ev_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] STARTUP_MAX = CNT_W'(STARTUP_CYCLES);
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [AW:0]      DEPTH_W     = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]      COUNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0]    PTR_ONE     = AW'(1);

   logic [7:0]       r_btnLevel;
   logic [7:0]       r_btnPrev;
   logic [CNT_W-1:0] r_startupCnt;
   logic [7:0]       r_pressPend;
   logic [7:0]       r_releasePend;
   logic [CNT_W-1:0] r_repCnt;
   logic             r_repPhase;
   logic             r_repPend;
   logic [2:0]       r_repTarget;
   logic [2:0]       r_fifoCode [FIFO_DEPTH];
   logic [1:0]       r_fifoType [FIFO_DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;

   logic             w_armed;
   logic [7:0]       w_rise;
   logic [7:0]       w_fall;
   logic [2:0]       w_target;
   logic             w_targetValid;
   logic             w_repHold;
   logic             w_repFire;
   logic             w_evPending;
   logic [2:0]       w_selCode;
   logic [1:0]       w_selType;
   logic             w_enq;
   logic             w_deq;
   logic [7:0]       w_pressClr;
   logic [7:0]       w_releaseClr;
   logic             w_repClr;

   assign w_armed       = (r_startupCnt == STARTUP_MAX);
   assign w_rise        = r_btnLevel & ~r_btnPrev;
   assign w_fall        = ~r_btnLevel & r_btnPrev;
   assign w_targetValid = |r_btnLevel[7:4];
   assign w_repHold     = w_armed && w_targetValid && (r_btnLevel[7:4] == r_btnPrev[7:4]);
   assign w_repFire     = w_repHold && (r_repPhase ? (r_repCnt == PERIOD_LAST)
                                                   : (r_repCnt == DELAY_LAST));

   assign ev_valid  = (r_count != '0);
   assign ev_count  = r_count;
   assign btn_level = r_btnLevel;
   assign ev_code   = r_fifoCode[r_rdPtr];
   assign ev_type   = r_fifoType[r_rdPtr];

   assign w_enq = (r_count < DEPTH_W) && (w_evPending || r_repPend);
   assign w_deq = ev_valid && ev_ready;

   assign w_pressClr   = (w_enq && w_evPending && (w_selType == 2'd0)) ? (8'b1 << w_selCode) : 8'b0;
   assign w_releaseClr = (w_enq && w_evPending && (w_selType == 2'd1)) ? (8'b1 << w_selCode) : 8'b0;
   assign w_repClr     = w_enq && !w_evPending;

   // Repeat target is the lowest-code direction currently held
   always_comb begin
      w_target = 3'd4;
      for (int i = 7; i >= 4; i--) begin
         if (r_btnLevel[i]) w_target = 3'(i);
      end
   end

   // Pick the next event: lowest-code edge first (press before release), then repeat
   always_comb begin
      w_evPending = 1'b0;
      w_selCode   = 3'd0;
      w_selType   = 2'd0;
      for (int i = 7; i >= 0; i--) begin
         if (r_pressPend[i] || r_releasePend[i]) begin
            w_evPending = 1'b1;
            w_selCode   = 3'(i);
            w_selType   = r_pressPend[i] ? 2'd0 : 2'd1;
         end
      end
      if (!w_evPending && r_repPend) begin
         w_selCode = w_target;
         w_selType = 2'd2;
      end
   end

   // Register the raw levels and keep one cycle of history for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_btnLevel <= 8'h00;
         r_btnPrev  <= 8'h00;
      end else begin
         r_btnLevel <= {right, left, down, up, start, select, B, A};
         r_btnPrev  <= r_btnLevel;
      end
   end

   // Startup holdoff counter saturates once the receiver has had time to scan
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_startupCnt <= '0;
      end else if (!w_armed) begin
         r_startupCnt <= r_startupCnt + CNT_ONE;
      end
   end

   // Sticky pending flags so an edge survives a full FIFO until it is queued
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pressPend   <= 8'h00;
         r_releasePend <= 8'h00;
         r_repPend     <= 1'b0;
         r_repTarget   <= 3'd0;
      end else if (!w_armed) begin
         r_pressPend   <= 8'h00;
         r_releasePend <= 8'h00;
         r_repPend     <= 1'b0;
      end else begin
         r_pressPend   <= (r_pressPend & ~w_pressClr) | w_rise;
         r_releasePend <= (r_releasePend & ~w_releaseClr) | w_fall;
         if (w_repFire) begin
            r_repPend   <= 1'b1;
            r_repTarget <= w_target;
         end else if (w_repClr || !r_btnLevel[r_repTarget]) begin
            r_repPend <= 1'b0;
         end
      end
   end

   // Repeat timer: initial delay phase, then periodic phase, restarts on any direction change
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_repCnt   <= '0;
         r_repPhase <= 1'b0;
      end else if (!w_repHold) begin
         r_repCnt   <= '0;
         r_repPhase <= 1'b0;
      end else if (w_repFire) begin
         r_repCnt   <= '0;
         r_repPhase <= 1'b1;
      end else begin
         r_repCnt <= r_repCnt + CNT_ONE;
      end
   end

   // Show-ahead event FIFO; reset empties it and clears the head outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifoCode[i] <= 3'd0;
            r_fifoType[i] <= 2'd0;
         end
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) begin
            r_fifoCode[r_wrPtr] <= w_selCode;
            r_fifoType[r_wrPtr] <= w_selType;
            r_wrPtr             <= r_wrPtr + PTR_ONE;
         end
         if (w_deq) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + COUNT_ONE;
            2'b01:   r_count <= r_count - COUNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_nes_button_events.sv
// Directed testbench for nes_button_events with short holdoff and repeat timings.
module tb_nes_button_events;

   localparam int STARTUP = 200;
   localparam int RDELAY  = 20;
   localparam int RPERIOD = 5;
   localparam int DEPTH   = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       A, B, select, start, up, down, left, right;
   logic       ev_valid;
   logic       ev_ready;
   logic [2:0] ev_code;
   logic [1:0] ev_type;
   logic [7:0] btn_level;
   logic [2:0] ev_count;

   int testCount = 0;
   int failCount = 0;
   int validSeen;

   nes_button_events #(
      .STARTUP_CYCLES (STARTUP),
      .REPEAT_DELAY   (RDELAY),
      .REPEAT_PERIOD  (RPERIOD),
      .FIFO_DEPTH     (DEPTH),
      .CNT_W          (25)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .A         (A),
      .B         (B),
      .select    (select),
      .start     (start),
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_code   (ev_code),
      .ev_type   (ev_type),
      .btn_level (btn_level),
      .ev_count  (ev_count)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      A      = b[0];
      B      = b[1];
      select = b[2];
      start  = b[3];
      up     = b[4];
      down   = b[5];
      left   = b[6];
      right  = b[7];
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkEvent(input string tag, input logic [2:0] code, input logic [1:0] kind);
      checkOutput({tag, "_valid"}, 32'(ev_valid), 32'd1);
      checkOutput({tag, "_code"}, 32'(ev_code), 32'(code));
      checkOutput({tag, "_type"}, 32'(ev_type), 32'(kind));
   endtask

   // Count cycles with ev_valid high over a window, changing inputs at a chosen cycle
   task automatic quietWindow(input int cycles, input int changeAt, input logic [7:0] newBtns);
      validSeen = 0;
      for (int c = 0; c < cycles; c++) begin
         if (c == changeAt) applyStimulus(newBtns);
         tick(1);
         if (ev_valid) validSeen++;
      end
   endtask

   initial begin
      // Holdoff: buttons all pressed through reset
      reset    = 1'b1;
      ev_ready = 1'b0;
      applyStimulus(8'hFF);
      tick(3);
      checkOutput("reset_valid", 32'(ev_valid), 32'd0);
      checkOutput("reset_count", 32'(ev_count), 32'd0);
      checkOutput("reset_level", 32'(btn_level), 32'h00);
      checkOutput("reset_code", 32'(ev_code), 32'd0);
      checkOutput("reset_type", 32'(ev_type), 32'd0);
      reset = 1'b0;
      tick(1);
      checkOutput("holdoff_level_ff", 32'(btn_level), 32'hFF);
      quietWindow(250, 99, 8'h00);
      checkOutput("holdoff_no_events", 32'(validSeen), 32'd0);
      checkOutput("holdoff_count", 32'(ev_count), 32'd0);
      checkOutput("holdoff_level_00", 32'(btn_level), 32'h00);

      // Single press then release of A
      ev_ready = 1'b1;
      applyStimulus(8'h01);
      tick(1);
      checkOutput("press_level", 32'(btn_level), 32'h01);
      tick(1);
      checkOutput("press_k1_idle", 32'(ev_valid), 32'd0);
      tick(1);
      checkEvent("press_A", 3'd0, 2'd0);
      tick(1);
      checkOutput("press_drained", 32'(ev_valid), 32'd0);
      tick(6);
      applyStimulus(8'h00);
      tick(2);
      checkOutput("release_k11_idle", 32'(ev_valid), 32'd0);
      tick(1);
      checkEvent("release_A", 3'd0, 2'd1);
      tick(1);
      checkOutput("release_drained", 32'(ev_valid), 32'd0);

      // Simultaneous start and left presses with consumer stalled
      ev_ready = 1'b0;
      applyStimulus(8'h48);
      tick(4);
      checkOutput("simul_count", 32'(ev_count), 32'd2);
      checkEvent("simul_head_start", 3'd3, 2'd0);
      tick(3);
      checkEvent("simul_stable", 3'd3, 2'd0);
      ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
      checkEvent("simul_second_left", 3'd6, 2'd0);
      checkOutput("simul_count_after_pop", 32'(ev_count), 32'd1);
      applyStimulus(8'h00);
      tick(6);
      checkOutput("simul_release_count", 32'(ev_count), 32'd3);
      ev_ready = 1'b1;
      tick(1);
      checkEvent("simul_rel_start", 3'd3, 2'd1);
      tick(1);
      checkEvent("simul_rel_left", 3'd6, 2'd1);
      tick(1);
      checkOutput("simul_empty", 32'(ev_count), 32'd0);

      // Auto-repeat on up: press at +2, repeats at +22/+27/+32/+37, release at +42
      applyStimulus(8'h10);
      for (int t = 0; t <= 44; t++) begin
         tick(1);
         if (t == 2) begin
            checkEvent($sformatf("rep_press_t%0d", t), 3'd4, 2'd0);
         end else if (t == 22 || t == 27 || t == 32 || t == 37) begin
            checkEvent($sformatf("rep_repeat_t%0d", t), 3'd4, 2'd2);
         end else if (t == 42) begin
            checkEvent($sformatf("rep_release_t%0d", t), 3'd4, 2'd1);
         end else begin
            checkOutput($sformatf("rep_idle_t%0d", t), 32'(ev_valid), 32'd0);
         end
         if (t == 39) applyStimulus(8'h00);
      end

      // Full FIFO backpressure: three B pulses while stalled
      ev_ready = 1'b0;
      for (int p = 0; p < 3; p++) begin
         applyStimulus(8'h02);
         tick(4);
         applyStimulus(8'h00);
         tick(4);
      end
      tick(10);
      checkOutput("full_count", 32'(ev_count), 32'd4);
      checkEvent("full_head", 3'd1, 2'd0);
      ev_ready = 1'b1;
      for (int e = 1; e < 6; e++) begin
         tick(1);
         checkEvent($sformatf("drain_%0d", e), 3'd1, 2'(e % 2));
      end
      tick(1);
      checkOutput("drain_empty_valid", 32'(ev_valid), 32'd0);
      checkOutput("drain_empty_count", 32'(ev_count), 32'd0);

      // Reset mid-stream with three events queued
      ev_ready = 1'b0;
      applyStimulus(8'h07);
      tick(6);
      checkOutput("pre_reset_count", 32'(ev_count), 32'd3);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_valid", 32'(ev_valid), 32'd0);
      checkOutput("async_reset_count", 32'(ev_count), 32'd0);
      checkOutput("async_reset_level", 32'(btn_level), 32'h00);
      tick(2);
      reset = 1'b0;
      quietWindow(220, 50, 8'h00);
      checkOutput("rearm_holdoff_quiet", 32'(validSeen), 32'd0);
      checkOutput("rearm_holdoff_count", 32'(ev_count), 32'd0);
      ev_ready = 1'b1;
      applyStimulus(8'h01);
      tick(2);
      checkOutput("rearm_k1_idle", 32'(ev_valid), 32'd0);
      tick(1);
      checkEvent("rearm_press_A", 3'd0, 2'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
